ras_front_ctrl: RTL and testbench

- Command front-end for the 16-entry return-address LIFO.
- Accepts CALL (push return address) and RET (pop return address) commands from the core's branch unit over a valid/ready handshake, and drives the LIFO's PUSH/POP/DTI.
- The LIFO's output is registered and its pointer is hidden, so this block:
  - waits for the LIFO output to settle before a RET is accepted;
  - tracks depth and overflow/underflow;
  - sequences a FLUSH that returns the LIFO pointer to its reset position.

---
 rtl/ras_pkg.sv | 15 +
 rtl/ras_front_ctrl_if.sv | 24 ++
 rtl/ras_front_ctrl.sv | 140 ++++++++++++++
 tb/tb_ras_front_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ras_pkg.sv
// Shared types and constants for the return-address stack front-end.
package ras_pkg;

  localparam int unsigned RAS_DEPTH    = 16;
  localparam int unsigned RAS_PTR_W    = 4;
  localparam int unsigned RAS_DEPTH_W  = 5;
  localparam int unsigned RAS_SETTLE   = 2;
  localparam int unsigned RAS_SETTLE_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } ras_state_t;

endpackage

// File: rtl/ras_front_ctrl_if.sv
// CALL/RET command handshake and RET result between the branch unit and the RAS front-end.
interface ras_front_ctrl_if #(
  parameter int unsigned DataWidth = 32
);

  logic                 CMD_VALID;
  logic                 CMD_CALL;
  logic [DataWidth-1:0] CMD_ADDR;
  logic                 CMD_READY;
  logic                 RET_VALID;
  logic [DataWidth-1:0] RET_ADDR;
  logic                 RET_ERR;

  modport master (
    output CMD_VALID, CMD_CALL, CMD_ADDR,
    input  CMD_READY, RET_VALID, RET_ADDR, RET_ERR
  );

  modport slave (
    input  CMD_VALID, CMD_CALL, CMD_ADDR,
    output CMD_READY, RET_VALID, RET_ADDR, RET_ERR
  );

endinterface

// File: rtl/ras_front_ctrl.sv
// Command front-end for the 16-entry return-address LIFO: CALL/RET handshake,
// settle gating for the registered LIFO output, depth/flag tracking and FLUSH.
module ras_front_ctrl
  import ras_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned LifoDepth = RAS_DEPTH
) (
  input  logic                   CLK,
  input  logic                   RESET,
  ras_front_ctrl_if.slave        cmd,
  input  logic                   FLUSH,
  output logic [RAS_DEPTH_W-1:0] DEPTH,
  output logic                   OVF,
  output logic                   UNF,
  output logic                   BUSY,
  output logic                   LIFO_PUSH,
  output logic                   LIFO_POP,
  output logic [DataWidth-1:0]   LIFO_DTI,
  input  logic [DataWidth-1:0]   LIFO_DTO
);

  localparam logic [RAS_DEPTH_W-1:0]  DepthFull  = RAS_DEPTH_W'(LifoDepth);
  localparam logic [RAS_SETTLE_W-1:0] SettleLoad = RAS_SETTLE_W'(RAS_SETTLE);

  ras_state_t                state, state_nxt;
  logic [RAS_DEPTH_W-1:0]    depth, depth_nxt;
  logic [RAS_PTR_W-1:0]      ptr, ptr_nxt;
  logic [RAS_SETTLE_W-1:0]   settle, settle_nxt;
  logic                      flush_pop, flush_pop_nxt;
  logic                      ret_valid, ret_valid_nxt;
  logic                      ret_err, ret_err_nxt;
  logic [DataWidth-1:0]      ret_addr, ret_addr_nxt;
  logic                      ovf, ovf_nxt;
  logic                      unf, unf_nxt;
  logic                      ready;
  logic                      push;
  logic                      pop;

  // Next-state, handshake and LIFO strobes
  always_comb begin
    state_nxt     = state;
    depth_nxt     = depth;
    ptr_nxt       = ptr;
    settle_nxt    = (settle != '0) ? settle - RAS_SETTLE_W'(1) : '0;
    flush_pop_nxt = flush_pop;
    ret_valid_nxt = 1'b0;
    ret_err_nxt   = 1'b0;
    ret_addr_nxt  = '0;
    ovf_nxt       = ovf;
    unf_nxt       = unf;
    ready         = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;

    unique case (state)
      ras_pkg::IDLE: begin
        // A RET must wait until the LIFO's registered top reflects the last push/pop.
        ready = !FLUSH && (cmd.CMD_CALL || settle == '0);
        if (FLUSH) begin
          state_nxt     = ras_pkg::FLUSH;
          ovf_nxt       = 1'b0;
          unf_nxt       = 1'b0;
          flush_pop_nxt = 1'b0;
        end else if (cmd.CMD_VALID && ready) begin
          if (cmd.CMD_CALL) begin
            push    = 1'b1;
            ptr_nxt = ptr + RAS_PTR_W'(1);
            if (depth == DepthFull) ovf_nxt = 1'b1;
            else                    depth_nxt = depth + RAS_DEPTH_W'(1);
          end else begin
            ret_valid_nxt = 1'b1;
            if (depth != '0) begin
              pop          = 1'b1;
              ptr_nxt      = ptr - RAS_PTR_W'(1);
              depth_nxt    = depth - RAS_DEPTH_W'(1);
              ret_addr_nxt = LIFO_DTO;
            end else begin
              ret_err_nxt = 1'b1;
              unf_nxt     = 1'b1;
            end
          end
        end
      end
      ras_pkg::FLUSH: begin
        // Walk the hidden LIFO pointer back to its reset position.
        if (ptr != '0) begin
          pop           = 1'b1;
          ptr_nxt       = ptr - RAS_PTR_W'(1);
          flush_pop_nxt = 1'b1;
        end else begin
          state_nxt = ras_pkg::IDLE;
          depth_nxt = '0;
          if (flush_pop) settle_nxt = SettleLoad;
        end
      end
    endcase

    if (push || pop) settle_nxt = SettleLoad;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= ras_pkg::IDLE;
      depth     <= '0;
      ptr       <= '0;
      settle    <= '0;
      flush_pop <= 1'b0;
      ret_valid <= 1'b0;
      ret_err   <= 1'b0;
      ret_addr  <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      state     <= state_nxt;
      depth     <= depth_nxt;
      ptr       <= ptr_nxt;
      settle    <= settle_nxt;
      flush_pop <= flush_pop_nxt;
      ret_valid <= ret_valid_nxt;
      ret_err   <= ret_err_nxt;
      ret_addr  <= ret_addr_nxt;
      ovf       <= ovf_nxt;
      unf       <= unf_nxt;
    end
  end

  assign cmd.CMD_READY = ready;
  assign cmd.RET_VALID = ret_valid;
  assign cmd.RET_ADDR  = ret_addr;
  assign cmd.RET_ERR   = ret_err;
  assign DEPTH         = depth;
  assign OVF           = ovf;
  assign UNF           = unf;
  assign BUSY          = (state == ras_pkg::FLUSH);
  assign LIFO_PUSH     = push;
  assign LIFO_POP      = pop;
  assign LIFO_DTI      = push ? cmd.CMD_ADDR : '0;

endmodule

// File: tb/tb_ras_front_ctrl.sv
// Bench for ras_front_ctrl: behavioural LIFO beside the DUT plus a stack-level reference model.
module tb_ras_front_ctrl;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [4:0]    depth;
  logic          ovf, unf, busy, lifo_push, lifo_pop;
  logic [DW-1:0] lifo_dti, lifo_dto;

  ras_front_ctrl_if #(.DataWidth(DW)) cmd_bus ();

  ras_front_ctrl #(.DataWidth(DW), .LifoDepth(16)) dut (
    .CLK      (clk),
    .RESET    (rst_n),
    .cmd      (cmd_bus),
    .FLUSH    (flush),
    .DEPTH    (depth),
    .OVF      (ovf),
    .UNF      (unf),
    .BUSY     (busy),
    .LIFO_PUSH(lifo_push),
    .LIFO_POP (lifo_pop),
    .LIFO_DTI (lifo_dti),
    .LIFO_DTO (lifo_dto)
  );

  always #5 clk = ~clk;

  // Behavioural LIFO: registered output, new top visible two cycles after PUSH/POP.
  logic [DW-1:0] lifo_mem [16];
  logic [3:0]    lifo_ptr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lifo_ptr <= '0;
      lifo_dto <= '0;
    end else begin
      lifo_dto <= lifo_mem[lifo_ptr - 4'd1];
      if (lifo_push) begin
        lifo_mem[lifo_ptr] <= lifo_dti;
        lifo_ptr           <= lifo_ptr + 4'd1;
      end else if (lifo_pop) begin
        lifo_ptr <= lifo_ptr - 4'd1;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [DW-1:0] m_stack[$];
  bit            m_ovf, m_unf, m_busy, m_fpop;
  logic [3:0]    m_ptr;
  int            cyc, last_op, busy_seen;
  bit            exp_rv, exp_re, acc;
  logic [DW-1:0] exp_ra;

  // One clock: check outputs at the falling edge, advance the model, return at posedge+1.
  task automatic cycle();
    bit rdy, e_push, e_pop, is_call;
    @(negedge clk);
    if (busy) busy_seen++;
    check("depth", 32'(depth), 32'(m_stack.size()));
    check("ovf", 32'(ovf), 32'(m_ovf));
    check("unf", 32'(unf), 32'(m_unf));
    check("busy", 32'(busy), 32'(m_busy));
    check("ret_valid", 32'(cmd_bus.RET_VALID), 32'(exp_rv));
    check("ret_err", 32'(cmd_bus.RET_ERR), 32'(exp_re));
    check("ret_addr", cmd_bus.RET_ADDR, exp_ra);
    is_call = cmd_bus.CMD_CALL;
    rdy     = !m_busy && !flush && (is_call || (cyc - last_op) >= 3);
    check("cmd_ready", 32'(cmd_bus.CMD_READY), 32'(rdy));
    acc    = cmd_bus.CMD_VALID && rdy;
    e_push = acc && is_call;
    e_pop  = (acc && !is_call && m_stack.size() > 0) || (m_busy && m_ptr != 4'd0);
    check("lifo_push", 32'(lifo_push), 32'(e_push));
    check("lifo_pop", 32'(lifo_pop), 32'(e_pop));
    check("lifo_dti", lifo_dti, e_push ? cmd_bus.CMD_ADDR : 32'd0);

    exp_rv = 1'b0;
    exp_re = 1'b0;
    exp_ra = '0;
    if (e_push || e_pop) last_op = cyc;
    if (m_busy) begin
      if (m_ptr != 4'd0) begin
        m_ptr--;
        m_fpop = 1'b1;
      end else begin
        m_busy = 1'b0;
        m_stack.delete();
        if (m_fpop) last_op = cyc;
      end
    end else if (flush) begin
      m_busy = 1'b1;
      m_fpop = 1'b0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else if (acc) begin
      if (is_call) begin
        if (m_stack.size() == 16) begin
          void'(m_stack.pop_front());
          m_ovf = 1'b1;
        end
        m_stack.push_back(cmd_bus.CMD_ADDR);
        m_ptr++;
      end else begin
        exp_rv = 1'b1;
        if (m_stack.size() > 0) begin
          exp_ra = m_stack.pop_back();
          m_ptr--;
        end else begin
          exp_re = 1'b1;
          m_unf  = 1'b1;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Present a command and hold it until accepted; waits = cycles spent not ready.
  task automatic issue(input bit call, input logic [DW-1:0] addr, output int waits);
    cmd_bus.CMD_VALID = 1'b1;
    cmd_bus.CMD_CALL  = call;
    cmd_bus.CMD_ADDR  = addr;
    waits = 0;
    cycle();
    while (!acc && waits < 60) begin
      waits++;
      cycle();
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    cmd_bus.CMD_VALID = 1'b0;
    cmd_bus.CMD_CALL  = 1'b0;
    cmd_bus.CMD_ADDR  = '0;
  endtask

  // Raise FLUSH for one cycle with a command already held; count cycles until it is accepted.
  task automatic flush_with_cmd(input bit call, output int waits);
    cmd_bus.CMD_VALID = 1'b1;
    cmd_bus.CMD_CALL  = call;
    cmd_bus.CMD_ADDR  = 32'hF00D;
    flush     = 1'b1;
    busy_seen = 0;
    cycle();
    check("flush_cmd_ignored", 32'(acc), 32'd0);
    flush = 1'b0;
    waits = 0;
    cycle();
    while (!acc && waits < 60) begin
      waits++;
      cycle();
    end
    if (!acc) check("flush_accept_timeout", 32'd0, 32'd1);
    cmd_bus.CMD_VALID = 1'b0;
    cmd_bus.CMD_CALL  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    rst_n             = 1'b0;
    flush             = 1'b0;
    cmd_bus.CMD_VALID = 1'b0;
    cmd_bus.CMD_CALL  = 1'b0;
    cmd_bus.CMD_ADDR  = '0;
    m_ovf = 0; m_unf = 0; m_busy = 0; m_fpop = 0; m_ptr = '0;
    exp_rv = 0; exp_re = 0; exp_ra = '0; acc = 0;
    cyc = 0; last_op = -10; busy_seen = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset / idle state
    idle(2);
    check("rst_ready", 32'(cmd_bus.CMD_READY), 32'd1);
    check("rst_depth", 32'(depth), 32'd0);

    // CALL, CALL, 2 idle, RET
    issue(1'b1, 32'h100, w);
    issue(1'b1, 32'h200, w);
    idle(2);
    issue(1'b0, '0, w);
    check("ret2_wait", 32'(w), 32'd0);
    check("ret2_addr", cmd_bus.RET_ADDR, 32'h200);
    check("ret2_depth", 32'(depth), 32'd1);

    // RET right behind a CALL stalls two cycles
    issue(1'b1, 32'h300, w);
    issue(1'b0, '0, w);
    check("settle_wait", 32'(w), 32'd2);
    check("settle_addr", cmd_bus.RET_ADDR, 32'h300);

    // Drain, then underflow
    idle(2);
    issue(1'b0, '0, w);
    check("drain_addr", cmd_bus.RET_ADDR, 32'h100);
    idle(2);
    issue(1'b0, '0, w);
    check("unf_err", 32'(cmd_bus.RET_ERR), 32'd1);
    check("unf_addr", cmd_bus.RET_ADDR, 32'd0);
    check("unf_flag", 32'(unf), 32'd1);
    idle(3);
    check("unf_sticky", 32'(unf), 32'd1);

    // Overflow: 17 CALLs then 17 RETs
    for (int i = 1; i <= 17; i++) issue(1'b1, 32'(i), w);
    check("ovf_depth", 32'(depth), 32'd16);
    check("ovf_flag", 32'(ovf), 32'd1);
    for (int i = 0; i < 17; i++) begin
      idle(2);
      issue(1'b0, '0, w);
      if (i < 16) check("ovf_ret_addr", cmd_bus.RET_ADDR, 32'(17 - i));
      else        check("ovf_ret_err", 32'(cmd_bus.RET_ERR), 32'd1);
    end

    // Flush back to pointer 0, then 5 CALLs and FLUSH with a RET held
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    idle(20);
    check("flush_ptr0", 32'(lifo_ptr), 32'd0);
    check("flush_clr_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 5; i++) issue(1'b1, 32'h500 + 32'(i), w);
    flush_with_cmd(1'b0, w);
    check("flush5_busy", 32'(busy_seen), 32'd6);
    check("flush5_ret_wait", 32'(w), 32'd8);
    check("flush5_ret_err", 32'(cmd_bus.RET_ERR), 32'd1);

    // FLUSH with a CALL held: accepted on the first idle cycle
    idle(3);
    for (int i = 0; i < 3; i++) issue(1'b1, 32'h700 + 32'(i), w);
    flush_with_cmd(1'b1, w);
    check("flush3_busy", 32'(busy_seen), 32'd4);
    check("flush3_call_wait", 32'(w), 32'd4);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (!cmd_bus.CMD_VALID && $urandom_range(0, 1) == 0) begin
        cmd_bus.CMD_VALID = 1'b1;
        cmd_bus.CMD_CALL  = ($urandom_range(0, 9) < 5);
        cmd_bus.CMD_ADDR  = $urandom;
      end
      flush = ($urandom_range(0, 59) == 0);
      cycle();
      if (acc) cmd_bus.CMD_VALID = 1'b0;
    end
    flush = 1'b0;
    cmd_bus.CMD_VALID = 1'b0;
    idle(20);
    check("final_ptr", 32'(lifo_ptr), 32'(m_ptr));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
